// File: rtl/pwl_alu_scheduler.sv
// Frame sequencer for the shared PWL synth ALU: one {chan, op} slot per cycle per sample tick,
// with CPU register-write windows granted only between frames and a sticky overrun flag.
module pwl_alu_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_BITS    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  input  logic [NUM_CHANNELS-1:0] chan_en,
  input  logic                    alu_stall,
  input  logic                    cpu_wr_req,
  input  logic                    overrun_clr,
  output logic                    alu_valid,
  output logic [1:0]              alu_op,
  output logic [CHAN_BITS-1:0]    alu_chan,
  output logic                    cpu_wr_ack,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [CHAN_BITS+1:0]      cnt, cnt_nxt;
  logic                      tick_pending, pending_nxt;
  logic [NUM_CHANNELS-1:0]   en_latched, en_nxt;
  logic                      frame_done_r, frame_done_nxt;
  logic                      overrun_r, overrun_nxt;
  logic                      advance;
  logic                      in_run;

  assign in_run     = (state == RUN);
  assign alu_chan   = cnt[CHAN_BITS+1:2];
  assign alu_op     = cnt[1:0];
  assign alu_valid  = in_run & en_latched[alu_chan];
  assign busy       = in_run;
  assign cpu_wr_ack = (state == GRANT);
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

  // Disabled slots never stall: alu_valid is low there, so the slot always advances.
  assign advance = ~(alu_valid & alu_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tick_pending <= 1'b0;
      en_latched   <= '0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tick_pending <= pending_nxt;
      en_latched   <= en_nxt;
      frame_done_r <= frame_done_nxt;
      overrun_r    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pending_nxt    = tick_pending;
    en_nxt         = en_latched;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_wr_req) begin
          state_nxt   = GRANT;
          pending_nxt = tick_pending | sample_tick;
        end else if (sample_tick | tick_pending) begin
          state_nxt   = RUN;
          cnt_nxt     = '0;
          en_nxt      = chan_en;
          pending_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (tick_pending | sample_tick) begin
          state_nxt   = RUN;
          cnt_nxt     = '0;
          en_nxt      = chan_en;
          pending_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (advance) begin
          cnt_nxt = cnt + 1'b1;
          if (&cnt) begin
            state_nxt      = IDLE;
            frame_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tick is an overrun when a frame is running or one is already queued; set beats clear.
  always_comb begin
    overrun_nxt = (sample_tick & (in_run | tick_pending)) | (overrun_r & ~overrun_clr);
  end

endmodule
